// File: rtl/ringosc_pkg.sv
// ringosc_pkg: shared types, constants and helpers for the ring-oscillator
// frequency meter.
//   state_t   : measurement FSM states
//   GATE_W    : gate-counter width for the default 1024-cycle window
//   byte_sel  : picks one byte of a (zero-extended) result word
`timescale 1ns/1ps
package ringosc_pkg;

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  localparam int GATE_CYCLES_DEF = 1024;
  localparam int GATE_W          = $clog2(GATE_CYCLES_DEF);

  // Bytes above the live result width read as 0 because callers zero-extend.
  function automatic logic [7:0] byte_sel(input logic [31:0] result,
                                          input logic [1:0]  sel);
    return result[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ringosc_edge_sync.sv
// ringosc_edge_sync: brings the free-running ring-oscillator output into the
// clk domain and produces a one-cycle pulse per rising edge.
// Optional macro RINGOSC_PRESCALE_EN inserts a divide-by-2 toggle flop
// clocked by osc_in ahead of the synchronizer.
// Ports:
//   clk, rst  : system clock, async active-high reset
//   osc_in    : raw oscillator, asynchronous to clk
//   edge_p    : one-cycle pulse per (possibly prescaled) rising edge
// Inputs faster than the sampling limit alias silently; nothing detects it.
`timescale 1ns/1ps
module ringosc_edge_sync
  import ringosc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic osc_in,
  output logic edge_p
);

  logic src;

`ifdef RINGOSC_PRESCALE_EN
  // Halving the rate lets the sampled signal stay below f_clk/2 while
  // osc_in itself runs up to f_clk.
  logic osc_div;
  always_ff @(posedge osc_in or posedge rst) begin
    if (rst) osc_div <= 1'b0;
    else     osc_div <= ~osc_div;
  end
  assign src = osc_div;
`else
  assign src = osc_in;
`endif

  // sync_q[0] is first-stage (metastable-prone); sync_q[SYNC_STAGES-1] oldest.
  logic [SYNC_STAGES-1:0] sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], src};
  end

  // Newer stage high, older stage low -> rising edge just arrived.
  assign edge_p = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ringosc_freq_meter.sv
// ringosc_freq_meter: counts ring-oscillator rising edges over a window of
// GATE_CYCLES clk cycles, in single-shot or continuous mode.
// Optional macro RINGOSC_PRESCALE_EN: counts osc/2 edges and reports
// edge_cnt<<1 (saturating), doubling the usable input frequency.
// Ports:
//   clk, rst      : system clock, async active-high reset
//   osc_in        : ring-oscillator output (async)
//   start         : one-cycle request for a measurement (ignored unless idle)
//   continuous    : re-arm after every result with no idle gap
//   rd_sel        : byte select for rd_byte
//   result        : last completed count, held between updates
//   result_valid  : one-cycle pulse in the cycle result updates
//   overflow      : the last result saturated
//   busy          : gate window open
//   rd_byte       : byte rd_sel of result (0 beyond CNT_W)
`timescale 1ns/1ps
module ringosc_freq_meter
  import ringosc_pkg::*;
#(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  input  logic             continuous,
  input  logic [1:0]       rd_sel,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             overflow,
  output logic             busy,
  output logic [7:0]       rd_byte
);

  localparam int GCW = $clog2(GATE_CYCLES);

  logic           edge_p;
  state_t         state;
  logic [GCW-1:0] gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic           ovf_int;

  ringosc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .osc_in (osc_in),
    .edge_p (edge_p)
  );

  // Count including this cycle's edge, so an edge in the final gate cycle
  // still lands in the result published on the GATE->DONE transition.
  logic             cnt_full, gate_last;
  logic [CNT_W-1:0] cnt_nxt, res_nxt;
  logic             ovf_nxt, ovf_res;

  assign cnt_full  = &edge_cnt;
  assign cnt_nxt   = (edge_p && !cnt_full) ? edge_cnt + 1'b1 : edge_cnt;
  assign ovf_nxt   = ovf_int | (edge_p & cnt_full);
  assign gate_last = (gate_cnt == GCW'(GATE_CYCLES - 1));

`ifdef RINGOSC_PRESCALE_EN
  // Doubling would drop the MSB; saturate instead and flag it.
  assign res_nxt = cnt_nxt[CNT_W-1] ? '1 : {cnt_nxt[CNT_W-2:0], 1'b0};
  assign ovf_res = ovf_nxt | cnt_nxt[CNT_W-1];
`else
  assign res_nxt = cnt_nxt;
  assign ovf_res = ovf_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      ovf_int      <= 1'b0;
      result       <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_valid <= 1'b0;
          if (start || continuous) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
            busy     <= 1'b1;
            state    <= GATE;
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt + 1'b1;
          edge_cnt <= cnt_nxt;
          ovf_int  <= ovf_nxt;
          if (gate_last) begin
            result       <= res_nxt;
            overflow     <= ovf_res;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          if (continuous) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
            busy     <= 1'b1;
            state    <= GATE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_byte = byte_sel(32'(result), rd_sel);

endmodule

// File: tb/tb_ringosc_freq_meter.sv
`timescale 1ns/1ps
module tb_ringosc_freq_meter;

  localparam int  GATE = 1024;
  localparam real TCLK = 10.0;
`ifdef RINGOSC_PRESCALE_EN
  localparam int TOL = 2;
`else
  localparam int TOL = 1;
`endif

  logic clk = 1'b0, rst = 1'b1, osc = 1'b0;
  logic start = 1'b0, continuous = 1'b0;
  logic [1:0] rd_sel = 2'd0;

  logic [15:0] result;
  logic        result_valid, overflow, busy;
  logic [7:0]  rd_byte;
  logic [7:0]  result8;
  logic        rv8, ovf8, busy8;
  logic [7:0]  rd_byte8;

  int  errors = 0, checks = 0;
  real osc_half = 40.0;

  always #5 clk = ~clk;
  always #(osc_half) osc = ~osc;

  ringosc_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start), .continuous(continuous),
    .rd_sel(rd_sel), .result(result), .result_valid(result_valid),
    .overflow(overflow), .busy(busy), .rd_byte(rd_byte)
  );

  ringosc_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start), .continuous(continuous),
    .rd_sel(rd_sel), .result(result8), .result_valid(rv8),
    .overflow(ovf8), .busy(busy8), .rd_byte(rd_byte8)
  );

  // Reference: ideal edge count in a GATE*TCLK window, then the reported
  // value after optional prescale and saturation to cntw bits.
  function automatic int model_res(input real period, input int cntw,
                                   output bit ovf);
    int n, lim, h;
    n   = $rtoi(GATE * TCLK / period);
    lim = (1 << cntw) - 1;
`ifdef RINGOSC_PRESCALE_EN
    h   = n / 2;
    ovf = (h >= (1 << (cntw - 1)));
    return ovf ? lim : 2 * h;
`else
    h   = n;
    ovf = (h > lim);
    return ovf ? lim : n;
`endif
  endfunction

  function automatic bit near(input int act, input int exp);
    return (act >= exp - TOL) && (act <= exp + TOL);
  endfunction

  task automatic set_period(input real p);
    osc_half = p / 2.0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Issues start, returns cycles to result_valid (-1 on timeout) and the
  // number of sampled cycles with busy high.
  task automatic measure(output int lat, output int bcnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcnt = busy ? 1 : 0;
    lat  = -1;
    for (int k = 1; k <= GATE + 50; k++) begin
      @(posedge clk); #1;
      if (result_valid) begin lat = k; break; end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    bit seen;
    rst = 1'b1; #1;
    checks++;
    if (result !== 16'd0 || busy !== 1'b0 || result_valid !== 1'b0 ||
        overflow !== 1'b0 || rd_byte !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: result=%0d busy=%b rv=%b ovf=%b rd_byte=%0d, need all 0",
               result, busy, result_valid, overflow, rd_byte);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (busy || result_valid) seen = 1; end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_idle: activity without start, need none");
    end
  endtask

  task automatic test_single_shot;
    int lat, bcnt, exp; bit eo;
    set_period(80.0);
    exp = model_res(80.0, 16, eo);
    measure(lat, bcnt);
    checks++;
    if (lat !== GATE) begin
      errors++; $display("FAIL single_latency: got %0d need %0d", lat, GATE);
    end
    checks++;
    if (bcnt !== GATE) begin
      errors++; $display("FAIL single_busy_len: got %0d need %0d", bcnt, GATE);
    end
    checks++;
    if (!near(int'(result), exp) || overflow !== 1'b0) begin
      errors++; $display("FAIL single_result: got %0d ovf=%b need %0d+-%0d ovf=0",
                         result, overflow, exp, TOL);
    end
    @(posedge clk); #1;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_pulse: rv=%b busy=%b need 0/0", result_valid, busy);
    end
  endtask

  task automatic test_random;
    int lat, bcnt, exp; bit eo; real p;
    for (int i = 0; i < 4; i++) begin
`ifdef RINGOSC_PRESCALE_EN
      p = real'($urandom_range(11, 400));
`else
      p = real'($urandom_range(22, 400));
`endif
      set_period(p);
      exp = model_res(p, 16, eo);
      measure(lat, bcnt);
      checks++;
      if (lat !== GATE || !near(int'(result), exp)) begin
        errors++; $display("FAIL random_%0d: period=%0.0f lat=%0d result=%0d need lat %0d result %0d+-%0d",
                           i, p, lat, result, GATE, exp, TOL);
      end
    end
  endtask

  task automatic test_overflow;
    int lat, bcnt, exp; bit eo;
    set_period(30.0);
    exp = model_res(30.0, 16, eo);
    measure(lat, bcnt);
    checks++;
    if (result8 !== 8'hFF || ovf8 !== 1'b1) begin
      errors++; $display("FAIL ovf_sat: got %0d ovf=%b need 255 ovf=1", result8, ovf8);
    end
    checks++;
    if (!near(int'(result), exp) || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_wide: got %0d ovf=%b need %0d ovf=0", result, overflow, exp);
    end
    set_period(800.0);
    exp = model_res(800.0, 8, eo);
    measure(lat, bcnt);
    checks++;
    if (!near(int'(result8), exp) || ovf8 !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %0d ovf=%b need %0d ovf=0", result8, ovf8, exp);
    end
  endtask

  task automatic test_continuous;
    int t[3]; int np, cyc, exp, after; bit eo;
    set_period(80.0);
    exp = model_res(80.0, 16, eo);
    continuous = 1'b1;
    np = 0; cyc = 0;
    while (np < 3 && cyc < 4 * (GATE + 2)) begin
      @(posedge clk); #1; cyc++;
      if (result_valid) begin
        t[np] = cyc; np++;
        checks++;
        if (!near(int'(result), exp)) begin
          errors++; $display("FAIL cont_result_%0d: got %0d need %0d", np, result, exp);
        end
      end
    end
    checks++;
    if (np !== 3) begin
      errors++; $display("FAIL cont_pulses: got %0d need 3", np);
    end else begin
      checks++;
      if (t[1] - t[0] !== GATE + 1 || t[2] - t[1] !== GATE + 1) begin
        errors++; $display("FAIL cont_spacing: got %0d,%0d need %0d", t[1]-t[0], t[2]-t[1], GATE+1);
      end
    end
    repeat (100) @(posedge clk);
    #1 continuous = 1'b0;
    after = 0;
    repeat (2 * GATE + 100) begin @(posedge clk); #1; if (result_valid) after++; end
    checks++;
    if (after !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL cont_drop: pulses=%0d busy=%b need 1/0", after, busy);
    end
  endtask

  task automatic test_start_ignored;
    int lat, bcnt, extra; bit bz;
    set_period(100.0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= GATE + 50; k++) begin
      @(posedge clk); #1;
      if (k == 300) start = 1'b1;
      if (k == 301) start = 1'b0;
      if (result_valid) begin lat = k; break; end
    end
    start = 1'b0;
    checks++;
    if (lat !== GATE) begin
      errors++; $display("FAIL ign_gate_len: got %0d need %0d", lat, GATE);
    end
    start = 1'b1;              // lands in the DONE cycle
    @(posedge clk); #1;
    start = 1'b0;
    extra = 0; bz = 0;
    repeat (GATE + 80) begin @(posedge clk); #1; if (result_valid) extra++; if (busy) bz = 1; end
    checks++;
    if (extra !== 0 || bz !== 1'b0) begin
      errors++; $display("FAIL ign_done: pulses=%0d busy_seen=%b need 0/0", extra, bz);
    end
  endtask

  task automatic test_readback;
    int lat, bcnt, exp; bit eo; logic [7:0] b0;
    set_period(25.0);
    exp = model_res(25.0, 16, eo);
    measure(lat, bcnt);
    checks++;
    if (!near(int'(result), exp)) begin
      errors++; $display("FAIL rb_result: got %0d need %0d", result, exp);
    end
    b0 = 8'(exp);
    rd_sel = 2'd0; #1;
    checks++;
    if (int'(rd_byte) < int'(b0) - TOL || int'(rd_byte) > int'(b0) + TOL) begin
      errors++; $display("FAIL rb_byte0: got %0d need %0d+-%0d", rd_byte, b0, TOL);
    end
    rd_sel = 2'd1; #1;
    checks++;
    if (rd_byte !== 8'(exp >> 8)) begin
      errors++; $display("FAIL rb_byte1: got %0d need %0d", rd_byte, exp >> 8);
    end
    for (int s = 2; s < 4; s++) begin
      rd_sel = 2'(s); #1;
      checks++;
      if (rd_byte !== 8'd0 || rd_byte8 !== 8'd0) begin
        errors++; $display("FAIL rb_byte%0d: got %0d/%0d need 0", s, rd_byte, rd_byte8);
      end
    end
    rd_sel = 2'd0;
  endtask

`ifdef RINGOSC_PRESCALE_EN
  task automatic test_prescale;
    int lat, bcnt, exp; bit eo;
    set_period(15.0);
    exp = model_res(15.0, 16, eo);
    measure(lat, bcnt);
    checks++;
    if (result[0] !== 1'b0 || !near(int'(result), exp)) begin
      errors++; $display("FAIL prescale: got %0d need even %0d+-%0d", result, exp, TOL);
    end
  endtask
`endif

  task automatic test_reset_midstream;
    bit seen;
    set_period(80.0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (result !== 16'd0 || busy !== 1'b0 || result_valid !== 1'b0 ||
        overflow !== 1'b0 || rd_byte !== 8'd0 || result8 !== 8'd0) begin
      errors++; $display("FAIL reset_mid: result=%0d busy=%b rv=%b ovf=%b rd_byte=%0d, need all 0",
                         result, busy, result_valid, overflow, rd_byte);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (busy || result_valid) seen = 1; end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_mid_idle: activity after reset, need none");
    end
  endtask

  initial begin
    test_reset;
    test_single_shot;
    test_random;
    test_overflow;
    test_continuous;
    test_start_ignored;
    test_readback;
`ifdef RINGOSC_PRESCALE_EN
    test_prescale;
`endif
    test_reset_midstream;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
